// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Turns a (start address, length) burst command into a sequence of RAM reads
//   and presents the returned words as a ready/valid stream. The RAM has one
//   cycle of read latency. A 2-entry skid FIFO plus a one-deep in-flight
//   tracker keep the issued-but-not-consumed word count at 2 or less, so
//   back-pressure never loses data.
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cmd_valid    burst command offered
//   o_cmd_ready    command accepted when high together with i_cmd_valid
//   i_cmd_addr     start word address (WIDTH bits)
//   i_cmd_len      burst length minus one, 0 means one word (LEN_W bits)
//   o_ram_rden     RAM read enable
//   o_ram_raddr    RAM read address (WIDTH bits)
//   i_ram_rdata    RAM read data, valid the cycle after an o_ram_rden cycle
//   o_data_valid   stream word available
//   i_data_ready   downstream accepts the word
//   o_data         stream word (32 bits)
//   o_data_last    marks the final word of the burst
//   o_busy         high whenever the controller is not idle
module ram_burst_reader #(
   parameter int WIDTH = 10,
   parameter int LEN_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [WIDTH-1:0] i_cmd_addr,
   input  logic [LEN_W-1:0] i_cmd_len,
   output logic             o_ram_rden,
   output logic [WIDTH-1:0] o_ram_raddr,
   input  logic [31:0]      i_ram_rdata,
   output logic             o_data_valid,
   input  logic             i_data_ready,
   output logic [31:0]      o_data,
   output logic             o_data_last,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};

   state_t           r_state;
   logic [WIDTH-1:0] r_addr;
   logic [LEN_W:0]   r_remaining;     // one bit wider: holds CMD_LEN+1 without overflow
   logic             r_inflight;
   logic             r_inflight_last;

   logic [31:0]      r_fifo_data [2];
   logic [1:0]       r_fifo_last;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   logic             w_accept;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;

   assign o_cmd_ready  = (r_state == S_IDLE);
   assign o_busy       = (r_state != S_IDLE);
   assign w_accept     = i_cmd_valid & o_cmd_ready;

   assign o_data_valid = (r_count != 2'd0);
   assign o_data       = r_fifo_data[r_rd_ptr];
   assign o_data_last  = r_fifo_last[r_rd_ptr];
   assign w_pop        = o_data_valid & i_data_ready;
   assign w_push       = r_inflight;

   // Issue while (occupancy + inflight - pop) < 2, rearranged as
   // occupancy + inflight < 2 + pop so the unsigned sum never underflows.
   // A same-cycle pop frees a slot, which is what sustains one word per cycle.
   assign w_issue      = (r_state == S_ISSUE) &&
                         (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
   assign o_ram_rden   = w_issue;
   assign o_ram_raddr  = r_addr;

   // Control FSM: sequences the burst and owns the address/length counters.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr      <= i_cmd_addr;
                  r_remaining <= {1'b0, i_cmd_len} + REM_ONE;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  r_addr      <= r_addr + {{(WIDTH-1){1'b0}}, 1'b1};  // wraps at 2^WIDTH
                  r_remaining <= r_remaining - REM_ONE;
                  if (r_remaining == REM_ONE) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The last word may still be in flight; wait for it to leave the head.
               if (w_pop && o_data_last) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-return capture and 2-entry stream FIFO.
   // NOTE: the FIFO storage is reset along with the pointers because o_data is
   // driven straight from the head entry and must read 0 out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_fifo_data[0]  <= '0;
         r_fifo_data[1]  <= '0;
         r_fifo_last     <= '0;
         r_wr_ptr        <= 1'b0;
         r_rd_ptr        <= 1'b0;
         r_count         <= '0;
      end else begin
         // Clearing r_inflight on reset is what drops a read issued before it.
         r_inflight      <= w_issue;
         r_inflight_last <= (r_remaining == REM_ONE);

         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= i_ram_rdata;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;

         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//   Directed bench for ram_burst_reader (WIDTH=10, LEN_W=8). The RAM model
//   returns its own address as data (RAM[i] = i) one cycle after a read.
//   Inputs change and outputs are sampled around the falling clock edge.
module tb_ram_burst_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic        ram_rden;
   logic [9:0]  ram_raddr;
   logic [31:0] ram_rdata;
   logic        data_valid;
   logic        data_ready;
   logic [31:0] data;
   logic        data_last;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_burst_reader #(.WIDTH(10), .LEN_W(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_addr   (cmd_addr),
      .i_cmd_len    (cmd_len),
      .o_ram_rden   (ram_rden),
      .o_ram_raddr  (ram_raddr),
      .i_ram_rdata  (ram_rdata),
      .o_data_valid (data_valid),
      .i_data_ready (data_ready),
      .o_data       (data),
      .o_data_last  (data_last),
      .o_busy       (busy)
   );

   // Synchronous-read RAM with RAM[i] = i.
   initial ram_rdata = 32'hDEAD_BEEF;
   always @(posedge clk) if (ram_rden) ram_rdata <= 32'(ram_raddr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
      check({tag, "_ram_rden"},   32'(ram_rden),   32'd0);
      check({tag, "_ram_raddr"},  32'(ram_raddr),  32'd0);
      check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_data"},       data,            32'd0);
      check({tag, "_data_last"},  32'(data_last),  32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
   endtask

   // Offers one command from idle and collects the whole burst. Expected data
   // for word k is (addr + k) mod 1024, last only on k == len. Tracks words
   // issued minus words popped as the independent occupancy+inflight model.
   // Called at a falling edge; returns at the falling edge after the final pop.
   task automatic run_burst(input string name, input logic [9:0] addr,
                            input logic [7:0] len, input bit toggle);
      int          idx, n_iss, cyc, first_cyc, last_cyc;
      bit          held, pop, viol;
      logic [31:0] hold_data;
      logic        hold_last;
      logic [9:0]  ea;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      #1;
      check({name, "_ready_at_offer"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      idx = 0; n_iss = 0; cyc = 1; first_cyc = -1; last_cyc = -1;
      held = 1'b0; viol = 1'b0;
      while (idx <= int'(len) && cyc < 200) begin
         data_ready = toggle ? cyc[0] : 1'b1;
         #1;
         if (busy !== 1'b1 || cmd_ready !== 1'b0) viol = 1'b1;
         pop = data_valid && data_ready;
         if (ram_rden) begin
            if (n_iss - idx - int'(pop) >= 2) viol = 1'b1;
            ea = addr + 10'(n_iss);
            check({name, "_raddr"}, 32'(ram_raddr), 32'(ea));
            n_iss++;
         end
         if (data_valid && first_cyc < 0) first_cyc = cyc;
         if (held) begin
            check({name, "_held_valid"}, 32'(data_valid), 32'd1);
            check({name, "_held_data"},  data,            hold_data);
            check({name, "_held_last"},  32'(data_last),  32'(hold_last));
         end
         held = 1'b0;
         if (pop) begin
            ea = addr + 10'(idx);
            check({name, "_data"}, data,           32'(ea));
            check({name, "_last"}, 32'(data_last), 32'(idx == int'(len)));
            idx++;
            last_cyc = cyc;
         end else if (data_valid) begin
            held      = 1'b1;
            hold_data = data;
            hold_last = data_last;
         end
         @(negedge clk);
         cyc++;
      end
      data_ready = 1'b1;
      #1;
      check({name, "_words"},        32'(idx),       32'(int'(len) + 1));
      check({name, "_issues"},       32'(n_iss),     32'(int'(len) + 1));
      check({name, "_first_valid"},  32'(first_cyc), 32'd3);
      check({name, "_bounds"},       32'(viol),      32'd0);
      if (!toggle) check({name, "_throughput"}, 32'(last_cyc - first_cyc), 32'(len));
      check({name, "_ready_after"},  32'(cmd_ready),  32'd1);
      check({name, "_busy_after"},   32'(busy),       32'd0);
      check({name, "_empty_after"},  32'(data_valid), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_len    = '0;
      data_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_reset");

      // Basic 4-word burst with latency and throughput checks.
      run_burst("b5", 10'd5, 8'd3, 1'b0);
      // Address wrap at the top of the space.
      run_burst("wrap", 10'h3FE, 8'd3, 1'b0);
      // Back-pressure with ready toggling every cycle.
      run_burst("stall", 10'd40, 8'd7, 1'b1);
      // Single-word bursts issued back-to-back.
      run_burst("one_a", 10'd20, 8'd0, 1'b0);
      run_burst("one_b", 10'd21, 8'd0, 1'b0);

      // Reset two cycles into an 8-word burst.
      cmd_addr  = 10'd100;
      cmd_len   = 8'd7;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outputs("mid_release");
      @(negedge clk);
      #1;
      check("post_reset_no_stale", 32'(data_valid), 32'd0);
      @(negedge clk);
      run_burst("post_reset", 10'd200, 8'd3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 10: RAM word-address width.
REQ-002 SHALL have parameter LEN_W, default 8: burst-length field width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 CMD_VALID  input  1  burst command offered.
REQ-007 CMD_READY  output  1  command accepted when high with CMD_VALID.
REQ-008 CMD_ADDR  input  WIDTH  start word address.
REQ-009 CMD_LEN  input  LEN_W  burst length minus one (0 = 1 word).
REQ-010 RAM_RDEN  output  1  RAM read enable.
REQ-011 RAM_RADDR  output  WIDTH  RAM read address.
REQ-012 RAM_RDATA  input  32  RAM read data, valid the cycle after the RAM_RDEN cycle.
REQ-013 DATA_VALID  output  1  stream word available.
REQ-014 DATA_READY  input  1  downstream accepts word.
REQ-015 DATA  output  32  stream word.
REQ-016 DATA_LAST  output  1  marks final word of burst.
REQ-017 BUSY  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-019 IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, latch addr=CMD_ADDR and remaining=CMD_LEN+1 (LEN_W+1 bits), go ISSUE.
REQ-020 CMD_READY SHALL be 0 outside IDLE. A command offered in ISSUE or DRAIN SHALL be held off, not dropped.
REQ-021 Buffer: 2-entry FIFO, each entry holding 32-bit data and a last flag. In-flight counter: 0 or 1 read issued but not yet captured.
REQ-022 ISSUE: RAM_RDEN SHALL be high iff (occupancy + inflight - pop) < 2, where pop = DATA_VALID&DATA_READY in the same cycle. RAM_RDEN is combinational from registers and DATA_READY.
REQ-023 RAM_RADDR SHALL equal the addr register. On each issue: addr+1 modulo 2^WIDTH (wraps at top), remaining-1.
REQ-024 The word issued with remaining==1 SHALL carry last=1. After that issue the FSM SHALL go to DRAIN.
REQ-025 The cycle after an issue, RAM_RDATA SHALL be written into the FIFO tail with its last tag, and inflight SHALL clear.
REQ-026 DATA_VALID = FIFO non-empty. DATA and DATA_LAST SHALL come from the FIFO head.
REQ-027 A simultaneous push and pop SHALL keep occupancy unchanged. Overflow is impossible by REQ-022.
REQ-028 DRAIN: on the handshake of the word with last=1, go to IDLE in the next cycle. CMD_READY rises that cycle.
REQ-029 Latency: accept edge E0; RAM_RDEN high in cycle after E0; data captured at E2; DATA_VALID high after E2 (3 edges command-to-data).
REQ-030 With DATA_READY held high, throughput SHALL be one word per cycle sustained.
REQ-031 With DATA_READY low, issuing SHALL stop once occupancy+inflight=2. DATA and DATA_LAST SHALL stay stable while DATA_VALID&!DATA_READY.
REQ-032 RAM_RDEN SHALL never assert in IDLE or DRAIN.

Reset
REQ-033 RST low SHALL asynchronously force: state IDLE, FIFO empty, inflight 0, addr 0, remaining 0.
REQ-034 Outputs during and after reset: CMD_READY=1, RAM_RDEN=0, RAM_RADDR=0, DATA_VALID=0, DATA=0, DATA_LAST=0, BUSY=0.
REQ-035 Reset mid-burst SHALL discard buffered and in-flight words. The RAM_RDATA returned for a pre-reset read SHALL be ignored.

Verification
REQ-036 Preload RAM[i]=i; cmd ADDR=5 LEN=3, DATA_READY=1 -> DATA 5,6,7,8 on consecutive cycles, LAST only on 8, first DATA_VALID 3 edges after accept.
REQ-037 ADDR=0x3FE LEN=3 (WIDTH=10) -> RAM_RADDR 0x3FE,0x3FF,0x000,0x001; data order preserved.
REQ-038 LEN=7, DATA_READY toggling 1010... -> all 8 words in order, no loss or duplication, RAM_RDEN never raises occupancy+inflight above 2, DATA stable while stalled.
REQ-039 LEN=0 -> single word with DATA_LAST=1; CMD_READY high the cycle after its handshake; back-to-back second command accepted immediately.
REQ-040 RST pulsed low two cycles into an 8-word burst -> all outputs at reset values immediately; a new burst afterwards returns correct data with no stale words.
